// File: rtl/fsk_tx_frame.sv
// Framed FSK transmitter: accepts a payload, Hamming-style encodes each nibble into a byte,
// then sends preamble + codeword as BIT_CYCLES-long symbols with a two-tone square wave.
// Optional macro FSK_TX_IDLE_MARK_EN: run the HALF1 mark tone on wave_out while IDLE/GAP.
module fsk_tx_frame #(
    parameter int               DATA_W     = 8,
    parameter int               PRE_W      = 8,
    parameter logic [PRE_W-1:0] PREAMBLE   = 8'hAA,
    parameter int               BIT_CYCLES = 64,
    parameter int               HALF0      = 8,
    parameter int               HALF1      = 4,
    parameter int               GAP_CYCLES = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [2*DATA_W-1:0]   codeword,
    output logic                  bit_out,
    output logic                  sig_valid,
    output logic                  wave_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW_W     = 2 * DATA_W;
    localparam int TOT_W    = PRE_W + CW_W;
    localparam int SYM_W    = $clog2(TOT_W + 1);
    localparam int CYC_MAX  = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int CYC_W    = $clog2(CYC_MAX + 1);
    localparam int HALF_MAX = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int TONE_W   = $clog2(HALF_MAX + 1);

    localparam logic [SYM_W-1:0]  SYM_PRE_LAST = SYM_W'(PRE_W - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST     = SYM_W'(TOT_W - 1);
    localparam logic [CYC_W-1:0]  CYC_BIT_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_GAP_LAST = CYC_W'(GAP_CYCLES - 1);
    localparam logic [TONE_W-1:0] TONE_H0_LAST = TONE_W'(HALF0 - 1);
    localparam logic [TONE_W-1:0] TONE_H1_LAST = TONE_W'(HALF1 - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic              wave_q, wave_d;
    logic [TOT_W-1:0]  shift_q, shift_d;
    logic [CW_W-1:0]   codeword_q, codeword_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic              accept;
    logic [TONE_W-1:0] tone_last;

    // Each nibble becomes {p0,d3,d2,d1,p4,d0,p2,p1}; p0 gives even parity over the byte.
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic [3:0]      n;
        logic            p0, p1, p2, p4;
        cw = '0;
        for (int k = 0; k < DATA_W / 4; k++) begin
            n  = d[4*k +: 4];
            p1 = n[0] ^ n[1] ^ n[3];
            p2 = n[0] ^ n[2] ^ n[3];
            p4 = n[1] ^ n[2] ^ n[3];
            p0 = ^{n[3], n[2], n[1], p4, n[0], p2, p1};
            cw[8*k +: 8] = {p0, n[3], n[2], n[1], p4, n[0], p2, p1};
        end
        return cw;
    endfunction

    assign accept    = data_valid && ready_q && (state_q == S_IDLE);
    assign tone_last = shift_q[TOT_W-1] ? TONE_H1_LAST : TONE_H0_LAST;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d    = state_q;
        sym_d      = sym_q;
        cyc_d      = cyc_q;
        tone_d     = tone_q;
        wave_d     = wave_q;
        shift_d    = shift_q;
        codeword_d = codeword_q;
        done_d     = 1'b0;

        // Idle/gap tone behaviour; overridden below on symbol starts.
`ifdef FSK_TX_IDLE_MARK_EN
        if (tone_q >= TONE_H1_LAST) begin
            wave_d = ~wave_q;
            tone_d = '0;
        end else begin
            tone_d = tone_q + TONE_W'(1);
        end
`else
        wave_d = 1'b0;
        tone_d = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    codeword_d = encode(data_in);
                    shift_d    = {PREAMBLE, codeword_d};
                    state_d    = S_PRE;
                    sym_d      = '0;
                    cyc_d      = '0;
                    wave_d     = 1'b1;
                    tone_d     = '0;
                end
            end

            S_PRE, S_DATA: begin
                if (cyc_q == CYC_BIT_LAST) begin
                    cyc_d   = '0;
                    shift_d = shift_q << 1;
                    wave_d  = 1'b1;
                    tone_d  = '0;
                    if (sym_q == SYM_LAST) begin
                        state_d = S_GAP;
                        sym_d   = '0;
                        done_d  = 1'b1;
`ifndef FSK_TX_IDLE_MARK_EN
                        wave_d  = 1'b0;
`endif
                    end else begin
                        sym_d = sym_q + SYM_W'(1);
                        if (sym_q == SYM_PRE_LAST) begin
                            state_d = S_DATA;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                    if (tone_q >= tone_last) begin
                        wave_d = ~wave_q;
                        tone_d = '0;
                    end else begin
                        wave_d = wave_q;
                        tone_d = tone_q + TONE_W'(1);
                    end
                end
            end

            default: begin
                if (cyc_q == CYC_GAP_LAST) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
        endcase

        // Ready is registered so it stays low through reset and rises one edge after release.
        ready_d = (state_d == S_IDLE);
    end

    // NOTE: every register, including the codeword, is cleared by reset so a mid-frame abort leaves nothing on air.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sym_q      <= '0;
            cyc_q      <= '0;
            tone_q     <= '0;
            wave_q     <= 1'b0;
            shift_q    <= '0;
            codeword_q <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from the same snapshot.
            state_q    <= state_d;
            sym_q      <= sym_d;
            cyc_q      <= cyc_d;
            tone_q     <= tone_d;
            wave_q     <= wave_d;
            shift_q    <= shift_d;
            codeword_q <= codeword_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    // The shift register empties to zero after the last symbol, so bit_out is 0 outside a frame.
    assign bit_out    = shift_q[TOT_W-1];
    assign codeword   = codeword_q;
    assign wave_out   = wave_q;
    assign data_ready = ready_q;
    assign frame_done = done_q;
    assign sig_valid  = (state_q == S_PRE) || (state_q == S_DATA);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fsk_tx_frame.sv
// Directed bench for fsk_tx_frame at default parameters: encode, frame timing, tones,
// busy-ignore, reset abort and the idle wave behaviour of FSK_TX_IDLE_MARK_EN.
module tb_fsk_tx_frame;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] codeword;
    logic        bit_out;
    logic        sig_valid;
    logic        wave_out;
    logic        busy;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    fsk_tx_frame dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .codeword   (codeword),
        .bit_out    (bit_out),
        .sig_valid  (sig_valid),
        .wave_out   (wave_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Walks one frame's 24 symbols from the first cycle after accept; returns at the first GAP cycle.
    task automatic run_symbols(input logic [23:0] exp_bits, input bit inject_busy, input bit check_tone);
        logic [23:0] got;
        int          sv_bad;
        got    = '0;
        sv_bad = 0;
        for (int rel = 0; rel < 1536; rel++) begin
            int sym;
            int off;
            logic exp_wave;
            sym = rel / 64;
            off = rel % 64;
            if (sig_valid !== 1'b1) sv_bad++;
            if (off == 32) got[23-sym] = bit_out;
            if (check_tone && sym < 2 && off < 16) begin
                exp_wave = exp_bits[23-sym] ? ((off / 4) % 2 == 0) : ((off / 8) % 2 == 0);
                check($sformatf("tone_s%0d_o%0d", sym, off), wave_out, exp_wave);
            end
            if (inject_busy && rel == 20 * 64) begin
                data_valid = 1'b1;
                data_in    = 8'h55;
            end
            if (inject_busy && rel == 20 * 64 + 100) data_valid = 1'b0;
            tick();
        end
        check("symbol_bits", got, exp_bits);
        check("sig_valid_held", sv_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic prev;

        rst        = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        ticks(3);
        check("rst_ready",    data_ready, 0);
        check("rst_codeword", codeword,   0);
        check("rst_bit",      bit_out,    0);
        check("rst_sig",      sig_valid,  0);
        check("rst_wave",     wave_out,   0);
        check("rst_busy",     busy,       0);
        check("rst_done",     frame_done, 0);

        rst = 1'b1;
        tick();
        check("ready_after_release", data_ready, 1);

`ifdef FSK_TX_IDLE_MARK_EN
        prev = wave_out;
        n    = 0;
        while (wave_out === prev && n < 12) begin tick(); n++; end
        check("idle_mark_toggles", (n < 12), 1);
        prev = wave_out;
        n    = 0;
        while (wave_out === prev && n < 12) begin tick(); n++; end
        check("idle_mark_half", n, 4);
`else
        bad = 0;
        repeat (20) begin
            if (wave_out !== 1'b0) bad++;
            tick();
        end
        check("idle_wave_low", bad, 0);
`endif

        // Frame 1: 8'h1F with full timing and tone checks.
        data_in    = 8'h1F;
        data_valid = 1'b1;
        tick();
        check("f1_codeword",  codeword,   16'h87FF);
        check("f1_sig_rise",  sig_valid,  1);
        check("f1_busy",      busy,       1);
        check("f1_ready_low", data_ready, 0);
        check("f1_first_bit", bit_out,    1);
        data_valid = 1'b0;
        data_in    = 8'hFF;
        run_symbols({8'hAA, 16'h87FF}, 1'b0, 1'b1);
        check("f1_done",     frame_done, 1);
        check("f1_gap_sig",  sig_valid,  0);
        check("f1_gap_busy", busy,       1);
        check("f1_gap_bit",  bit_out,    0);
`ifdef FSK_TX_IDLE_MARK_EN
        check("f1_gap_wave", wave_out,   1);
`else
        check("f1_gap_wave", wave_out,   0);
`endif
        check("f1_gap_ready", data_ready, 0);
        tick();
        check("f1_done_pulse", frame_done, 0);
        ticks(14);
        check("f1_gap_end_ready", data_ready, 0);
        check("f1_gap_end_busy",  busy,       1);
        tick();
        check("f1_idle_ready", data_ready, 1);
        check("f1_idle_busy",  busy,       0);
        check("f1_hold_cw",    codeword,   16'h87FF);

        // Frame 2: 8'h00 with data_valid held, so frame 3 follows back-to-back.
        data_in    = 8'h00;
        data_valid = 1'b1;
        tick();
        check("f2_codeword", codeword,  16'h0000);
        check("f2_sig_rise", sig_valid, 1);
        run_symbols({8'hAA, 16'h0000}, 1'b0, 1'b0);
        n = 0;
        while (sig_valid !== 1'b1 && n < 40) begin tick(); n++; end
        check("b2b_separation", n, 17);
        check("f3_busy",  busy,       1);
        check("f3_ready", data_ready, 0);
        data_valid = 1'b0;

        // Abort frame 3 inside symbol 10.
        ticks(10 * 64 + 5);
        check("f3_mid_sig", sig_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_sig",      sig_valid,  0);
        check("abort_busy",     busy,       0);
        check("abort_bit",      bit_out,    0);
        check("abort_wave",     wave_out,   0);
        check("abort_codeword", codeword,   0);
        check("abort_ready",    data_ready, 0);
        check("abort_done",     frame_done, 0);
        ticks(3);
        rst = 1'b1;
        tick();
        check("abort_ready_back", data_ready, 1);
        bad = 0;
        repeat (30) begin
            if (frame_done !== 1'b0) bad++;
            tick();
        end
        check("abort_no_done", bad, 0);
        check("abort_idle", busy, 0);

        // Frame 4: 8'hA5, offered 8'h55 while in DATA must be ignored.
        data_in    = 8'hA5;
        data_valid = 1'b1;
        tick();
        check("f4_codeword", codeword, 16'hD22D);
        data_valid = 1'b0;
        run_symbols({8'hAA, 16'hD22D}, 1'b1, 1'b0);
        check("f4_done",    frame_done, 1);
        check("f4_hold_cw", codeword,   16'hD22D);
        ticks(16);
        check("f4_idle_ready", data_ready, 1);
        ticks(5);
        check("f4_no_second_busy", busy,      0);
        check("f4_no_second_sig",  sig_valid, 0);
        check("f4_final_cw",       codeword,  16'hD22D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
